// File: rtl/vscale_ext_irq_ctrl_pkg.sv
// Shared constants for the external interrupt controller: platform source
// count, register word offsets and trigger-mode encodings.
package vscale_ext_irq_ctrl_pkg;

    localparam int N_EXT_INTS = 24;

    localparam logic [1:0] EXT_IRQ_ADDR_PENDING = 2'd0;
    localparam logic [1:0] EXT_IRQ_ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] EXT_IRQ_ADDR_MODE    = 2'd2;
    localparam logic [1:0] EXT_IRQ_ADDR_CLAIM   = 2'd3;

    localparam logic EXT_IRQ_MODE_EDGE  = 1'b1;
    localparam logic EXT_IRQ_MODE_LEVEL = 1'b0;

    localparam int EXT_IRQ_ID_W = 6;

endpackage

// File: rtl/vscale_ext_irq_ctrl_if.sv
// Word-addressed register port of the external interrupt controller.
// One access per cycle, registered read data, no backpressure.
interface vscale_ext_irq_ctrl_if;

    logic        req;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output req, output we, output addr, output wdata, input rdata);
    modport slave  (input req, input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/vscale_irq_prio_enc.sv
// Lowest-index encoder over the enabled pending sources: returns 1-based id
// (0 when nothing is requesting) and a one-hot mask of the chosen source.
module vscale_irq_prio_enc
    import vscale_ext_irq_ctrl_pkg::*;
#(
    parameter int N_SRC = N_EXT_INTS
) (
    input  logic [N_SRC-1:0]        req_vec,
    output logic [EXT_IRQ_ID_W-1:0] id,
    output logic [N_SRC-1:0]        clr_mask
);

    // Scanning downward lets the lowest set index overwrite the result last.
    always_comb begin
        id       = '0;
        clr_mask = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                id          = EXT_IRQ_ID_W'(i + 1);
                clr_mask    = '0;
                clr_mask[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vscale_ext_irq_ctrl.sv
// External interrupt controller feeding the CSR file's mip. Define
// VSCALE_EXT_IRQ_SYNC_EN to add a two-flop synchronizer on every source line.
module vscale_ext_irq_ctrl
    import vscale_ext_irq_ctrl_pkg::*;
#(
    parameter int N_SRC = N_EXT_INTS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_SRC-1:0]          irq_in,
    vscale_ext_irq_ctrl_if.slave      bus,
    output logic [N_SRC-1:0]          ext_interrupts
);

    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] prev;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] pending_nxt;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] claim_mask;
    logic [EXT_IRQ_ID_W-1:0] claim_id;
    logic [31:0] rd_word;
    logic [31:0] wdata_unused;
    logic wr, rd, claim_rd;

`ifdef VSCALE_EXT_IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1;
    logic [N_SRC-1:0] sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = irq_in;
`endif

    assign wdata_unused = bus.wdata;
    assign wr       = bus.req & bus.we;
    assign rd       = bus.req & ~bus.we;
    assign claim_rd = rd && (bus.addr == EXT_IRQ_ADDR_CLAIM);

    vscale_irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
        .req_vec  (pending & enable),
        .id       (claim_id),
        .clr_mask (claim_mask)
    );

    // A fresh edge is ORed in after the clear so it beats a same-cycle W1C/claim.
    always_comb begin
        clr = '0;
        if (wr && (bus.addr == EXT_IRQ_ADDR_PENDING))
            clr = clr | bus.wdata[N_SRC-1:0];
        if (claim_rd)
            clr = clr | claim_mask;
        pending_nxt = (mode & ((pending & ~clr) | (s & ~prev))) | (~mode & s);
    end

    always_comb begin
        rd_word = '0;
        case (bus.addr)
            EXT_IRQ_ADDR_PENDING: rd_word[N_SRC-1:0]        = pending;
            EXT_IRQ_ADDR_ENABLE:  rd_word[N_SRC-1:0]        = enable;
            EXT_IRQ_ADDR_MODE:    rd_word[N_SRC-1:0]        = mode;
            EXT_IRQ_ADDR_CLAIM:   rd_word[EXT_IRQ_ID_W-1:0] = claim_id;
            default:              rd_word                   = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev           <= '0;
            pending        <= '0;
            enable         <= '0;
            mode           <= '0;
            bus.rdata      <= '0;
            ext_interrupts <= '0;
        end else begin
            prev           <= s;
            pending        <= pending_nxt;
            ext_interrupts <= pending & enable;
            if (wr && (bus.addr == EXT_IRQ_ADDR_ENABLE))
                enable <= bus.wdata[N_SRC-1:0];
            if (wr && (bus.addr == EXT_IRQ_ADDR_MODE))
                mode <= bus.wdata[N_SRC-1:0];
            if (rd)
                bus.rdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_vscale_ext_irq_ctrl.sv
// Directed self-checking bench for vscale_ext_irq_ctrl; expected values are
// hand-derived, with synchronizer latency folded in when VSCALE_EXT_IRQ_SYNC_EN is set.
module tb_vscale_ext_irq_ctrl;
    import vscale_ext_irq_ctrl_pkg::*;

    localparam int N = N_EXT_INTS;
`ifdef VSCALE_EXT_IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;
    logic [N-1:0] ext_interrupts;
    logic [31:0]  rd_val;
    int           n_checks = 0;
    int           n_fail   = 0;

    vscale_ext_irq_ctrl_if bus_if ();

    vscale_ext_irq_ctrl #(.N_SRC(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .irq_in         (irq_in),
        .bus            (bus_if),
        .ext_interrupts (ext_interrupts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.req   = 1'b1;
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        @(negedge clk);
        bus_if.req   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.wdata = '0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        bus_if.req  = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = a;
        @(negedge clk);
        bus_if.req  = 1'b0;
        d = bus_if.rdata;
    endtask

    initial begin
        reset        = 1'b1;
        irq_in       = '0;
        bus_if.req   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = '0;
        bus_if.wdata = '0;
        idle(3);
        reset = 1'b0;

        // Reset state
        check("reset_ext", 32'(ext_interrupts), 32'h0);
        check("reset_rdata", bus_if.rdata, 32'h0);
        reg_read(EXT_IRQ_ADDR_PENDING, rd_val); check("reset_pending", rd_val, 32'h0);
        reg_read(EXT_IRQ_ADDR_ENABLE, rd_val);  check("reset_enable", rd_val, 32'h0);
        reg_read(EXT_IRQ_ADDR_MODE, rd_val);    check("reset_mode", rd_val, 32'h0);
        reg_read(EXT_IRQ_ADDR_CLAIM, rd_val);   check("reset_claim", rd_val, 32'h0);

        // Edge source 0: one-cycle pulse, output latency, then W1C
        reg_write(EXT_IRQ_ADDR_MODE, 32'h1);
        reg_write(EXT_IRQ_ADDR_ENABLE, 32'h1);
        reg_read(EXT_IRQ_ADDR_MODE, rd_val);   check("mode_rb", rd_val, 32'h1);
        reg_read(EXT_IRQ_ADDR_ENABLE, rd_val); check("enable_rb", rd_val, 32'h1);
        irq_in[0] = 1'b1;
        idle(1);
        irq_in[0] = 1'b0;
        idle(LAT);
        check("edge0_not_yet", 32'(ext_interrupts), 32'h0);
        idle(1);
        check("edge0_rise", 32'(ext_interrupts), 32'h1);
        idle(3);
        check("edge0_held", 32'(ext_interrupts), 32'h1);
        reg_write(EXT_IRQ_ADDR_PENDING, 32'h1);
        check("w1c_same_edge", 32'(ext_interrupts), 32'h1);
        idle(1);
        check("w1c_out_low", 32'(ext_interrupts), 32'h0);
        reg_read(EXT_IRQ_ADDR_PENDING, rd_val); check("w1c_pending", rd_val, 32'h0);

        // New edge coincident with W1C: edge wins
        irq_in[0] = 1'b1;
        idle(LAT);
        reg_write(EXT_IRQ_ADDR_PENDING, 32'h1);
        reg_read(EXT_IRQ_ADDR_PENDING, rd_val); check("edge_vs_w1c", rd_val, 32'h1);
        irq_in[0] = 1'b0;
        idle(LAT + 2);
        reg_write(EXT_IRQ_ADDR_PENDING, 32'h1);
        reg_read(EXT_IRQ_ADDR_PENDING, rd_val); check("w1c_after_drop", rd_val, 32'h0);

        // Level sources 3 and 5: claim does not clear
        reg_write(EXT_IRQ_ADDR_MODE, 32'h0);
        reg_write(EXT_IRQ_ADDR_ENABLE, 32'h28);
        irq_in[3] = 1'b1;
        irq_in[5] = 1'b1;
        idle(LAT + 2);
        check("level_ext", 32'(ext_interrupts), 32'h28);
        reg_read(EXT_IRQ_ADDR_CLAIM, rd_val); check("level_claim_a", rd_val, 32'd4);
        reg_read(EXT_IRQ_ADDR_CLAIM, rd_val); check("level_claim_b", rd_val, 32'd4);
        irq_in[3] = 1'b0;
        idle(LAT + 2);
        reg_read(EXT_IRQ_ADDR_CLAIM, rd_val); check("level_claim_c", rd_val, 32'd6);
        reg_write(EXT_IRQ_ADDR_PENDING, 32'h20);
        reg_read(EXT_IRQ_ADDR_PENDING, rd_val); check("level_w1c_noeff", rd_val, 32'h20);
        irq_in[5] = 1'b0;
        idle(LAT + 2);
        reg_read(EXT_IRQ_ADDR_PENDING, rd_val); check("level_drop", rd_val, 32'h0);

        // Edge sources 2 and 7: back-to-back claims
        reg_write(EXT_IRQ_ADDR_MODE, 32'h84);
        reg_write(EXT_IRQ_ADDR_ENABLE, 32'h84);
        irq_in[2] = 1'b1;
        irq_in[7] = 1'b1;
        idle(1);
        irq_in[2] = 1'b0;
        irq_in[7] = 1'b0;
        idle(LAT + 2);
        reg_read(EXT_IRQ_ADDR_CLAIM, rd_val); check("claim_1", rd_val, 32'd3);
        reg_read(EXT_IRQ_ADDR_CLAIM, rd_val); check("claim_2", rd_val, 32'd8);
        reg_read(EXT_IRQ_ADDR_CLAIM, rd_val); check("claim_3", rd_val, 32'd0);
        reg_read(EXT_IRQ_ADDR_PENDING, rd_val); check("claim_pending", rd_val, 32'h0);
        idle(1);
        check("claim_ext", 32'(ext_interrupts), 32'h0);

        // Source 1 pending while disabled, then enabled, then reset
        reg_write(EXT_IRQ_ADDR_ENABLE, 32'h0);
        reg_write(EXT_IRQ_ADDR_MODE, 32'h2);
        irq_in[1] = 1'b1;
        idle(1);
        irq_in[1] = 1'b0;
        idle(LAT + 2);
        check("dis_ext", 32'(ext_interrupts), 32'h0);
        reg_read(EXT_IRQ_ADDR_CLAIM, rd_val);   check("dis_claim", rd_val, 32'h0);
        reg_read(EXT_IRQ_ADDR_PENDING, rd_val); check("dis_pending", rd_val, 32'h2);
        reg_write(EXT_IRQ_ADDR_ENABLE, 32'h2);
        check("en_same_edge", 32'(ext_interrupts), 32'h0);
        idle(1);
        check("en_rise", 32'(ext_interrupts), 32'h2);
        check("rdata_hold", bus_if.rdata, 32'h2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("rst_ext", 32'(ext_interrupts), 32'h0);
        check("rst_rdata", bus_if.rdata, 32'h0);
        reg_read(EXT_IRQ_ADDR_PENDING, rd_val); check("rst_pending", rd_val, 32'h0);
        reg_read(EXT_IRQ_ADDR_ENABLE, rd_val);  check("rst_enable", rd_val, 32'h0);
        reg_read(EXT_IRQ_ADDR_MODE, rd_val);    check("rst_mode", rd_val, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
